// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC register, word-addressed instruction memory
// with a loader write port, and the IF/ID pipeline register with decode
// field slices. Handles stall plus jump/branch redirects with a one-cycle
// squash of the wrong-path fetch.
module instr_fetch #(
  parameter int unsigned IMEM_AW  = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [15:0]        branch_imm,
  input  logic               jump,
  input  logic [25:0]        jump_index,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_waddr,
  input  logic [31:0]        imem_wdata,
  output logic [31:0]        pc,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic [5:0]         op,
  output logic [5:0]         func,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [31:0]        fetch_count
);

  localparam int unsigned DEPTH = 2 ** IMEM_AW;

  logic [31:0]        imem [DEPTH];
  logic [IMEM_AW-1:0] raddr;
  logic [31:0]        fetch_word;
  logic [31:0]        pc_plus4;
  logic [31:0]        branch_target;
  logic [31:0]        jump_target;
  logic               redirect;

  // Combinational fetch read and next-PC candidates
  always_comb begin
    raddr         = pc[IMEM_AW+1:2];
    fetch_word    = imem[raddr];
    pc_plus4      = pc + 32'd4;
    branch_target = if_id_pc4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    jump_target   = {if_id_pc4[31:28], jump_index, 2'b00};
    redirect      = if_id_valid && (jump || branch_taken);
  end

  // Synchronous loader write; the same-edge fetch still sees the old word
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  // PC and IF/ID register: stall holds everything, a redirect squashes
  // the slot fetched down the wrong path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
    end else if (!stall) begin
      if (redirect) begin
        pc          <= jump ? jump_target : branch_target;
        if_id_instr <= '0;
        if_id_valid <= 1'b0;
      end else begin
        pc          <= pc_plus4;
        if_id_instr <= fetch_word;
        if_id_pc4   <= pc_plus4;
        if_id_valid <= 1'b1;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  // Decode field slices of the latched instruction
  assign op   = if_id_instr[31:26];
  assign rs   = if_id_instr[25:21];
  assign rt   = if_id_instr[20:16];
  assign rd   = if_id_instr[15:11];
  assign func = if_id_instr[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the stage.
module tb_instr_fetch;

  localparam int unsigned AW = 8;
  localparam int unsigned DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [15:0]   branch_imm = '0;
  logic          jump = 1'b0;
  logic [25:0]   jump_index = '0;
  logic          imem_we = 1'b0;
  logic [AW-1:0] imem_waddr = '0;
  logic [31:0]   imem_wdata = '0;
  logic [31:0]   pc, if_id_instr, if_id_pc4, fetch_count;
  logic          if_id_valid;
  logic [5:0]    op, func;
  logic [4:0]    rs, rt, rd;

  instr_fetch #(.IMEM_AW(AW), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_imm(branch_imm), .jump(jump), .jump_index(jump_index),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .op(op), .func(func), .rs(rs), .rt(rt),
    .rd(rd), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] tbmem [DEPTH];
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("pc", pc, m_pc);
    chk("valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    chk("instr", if_id_instr, m_instr);
    chk("count", fetch_count, m_count);
    if (m_valid) chk("pc4", if_id_pc4, m_pc4);
    chk("op", {26'b0, op}, {26'b0, m_instr[31:26]});
    chk("func", {26'b0, func}, {26'b0, m_instr[5:0]});
    chk("rs", {27'b0, rs}, {27'b0, m_instr[25:21]});
    chk("rt", {27'b0, rt}, {27'b0, m_instr[20:16]});
    chk("rd", {27'b0, rd}, {27'b0, m_instr[15:11]});
  endtask

  // One clock: drive inputs, advance the model by the stage's rules, check
  task automatic step(input logic r, input logic s, input logic br,
                      input logic [15:0] imm, input logic j,
                      input logic [25:0] ji, input logic we,
                      input logic [AW-1:0] wa, input logic [31:0] wd);
    logic [31:0] fetched;
    int          off;
    reset = r; stall = s; branch_taken = br; branch_imm = imm;
    jump = j; jump_index = ji; imem_we = we; imem_waddr = wa; imem_wdata = wd;
    @(posedge clk);
    fetched = tbmem[m_pc[AW+1:2]];
    if (r) begin
      m_pc = 32'h0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_count = 0;
    end else if (!s) begin
      if (m_valid && (j || br)) begin
        if (j) m_pc = {m_pc4[31:28], ji, 2'b00};
        else begin
          off  = int'($signed(imm)) * 4;
          m_pc = m_pc4 + 32'(off);
        end
        m_valid = 0; m_instr = 0;
      end else begin
        m_instr = fetched; m_pc4 = m_pc + 4; m_valid = 1;
        m_count = m_count + 1; m_pc = m_pc + 4;
      end
    end
    if (we) tbmem[wa] = wd;
    #1;
    chk_all();
  endtask

  task automatic nop();
    step(0, 0, 0, '0, 0, '0, 0, '0, '0);
  endtask

  logic [31:0] saved, old_word;
  logic [AW-1:0] waddr;
  logic [31:0] init_words [4];

  initial begin
    init_words[0] = 32'h012A4020; init_words[1] = 32'h8D090004;
    init_words[2] = 32'hAD090008; init_words[3] = 32'h00000000;
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_count = 0;
    for (int i = 0; i < int'(DEPTH); i++) tbmem[i] = 32'hx;

    // Preload memory under reset
    for (int i = 0; i < int'(DEPTH); i++)
      step(1, 0, 0, '0, 0, '0, 1, AW'(i), (i < 4) ? init_words[i] : $urandom);
    chk("rst_pc4", if_id_pc4, 32'h0);

    // Sequential fetch of the preloaded program
    nop();
    chk("w0_instr", if_id_instr, 32'h012A4020);
    chk("w0_func", {26'b0, func}, 32'd32);
    nop();
    chk("w1_op", {26'b0, op}, 32'd35);
    nop();
    chk("w2_op", {26'b0, op}, 32'd43);
    nop();
    chk("w3_count", fetch_count, 32'd4);
    chk("w3_pc", pc, 32'h10);

    // Asynchronous reset mid-cycle with pc=8
    step(1, 0, 0, '0, 0, '0, 0, '0, '0);
    nop(); nop();
    chk("pre_rst_pc", pc, 32'h8);
    reset = 1'b1;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_valid", {31'b0, if_id_valid}, 32'h0);
    chk("async_count", fetch_count, 32'h0);
    step(1, 0, 0, '0, 0, '0, 0, '0, '0);

    // Stall with pc=4
    nop();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, '0, 0, '0, 0, '0, '0);
      chk("stall_pc", pc, 32'h4);
    end
    nop();
    chk("resume_instr", if_id_instr, 32'h8D090004);

    // Backward branch from if_id_pc4=8
    chk("br_pc4", if_id_pc4, 32'h8);
    step(0, 0, 1, 16'hFFFE, 0, '0, 0, '0, '0);
    chk("br_pc", pc, 32'h0);
    chk("br_valid", {31'b0, if_id_valid}, 32'h0);
    nop();
    chk("br_deliver", if_id_instr, 32'h012A4020);

    // Jump to the top of the low region, run across into 0x1000_0000
    step(0, 0, 0, '0, 1, 26'h3FF_FFFF, 0, '0, '0);
    chk("jmp1_pc", pc, 32'h0FFF_FFFC);
    for (int i = 0; i < 5; i++) nop();
    chk("jmp2_pc4", if_id_pc4, 32'h1000_0010);
    step(0, 0, 0, '0, 1, 26'h000_0040, 0, '0, '0);
    chk("jmp2_pc", pc, 32'h1000_0100);
    chk("jmp2_instr", if_id_instr, 32'h0);

    // Stalled jump+branch, then jump wins once stall drops
    nop();
    saved = m_pc;
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, 16'h0010, 1, 26'h000_0080, 0, '0, '0);
      chk("stall_redir_pc", pc, saved);
    end
    step(0, 0, 1, 16'h0010, 1, 26'h000_0080, 0, '0, '0);
    chk("jmp_over_br", pc, 32'h1000_0200);

    // Write to the word being fetched: old word latched, new on refetch
    nop();
    waddr    = m_pc[AW+1:2];
    old_word = tbmem[waddr];
    saved    = m_pc;
    step(0, 0, 0, '0, 0, '0, 1, waddr, 32'hCAFE_F00D);
    chk("wr_old", if_id_instr, old_word);
    step(0, 0, 1, 16'hFFFF, 0, '0, 0, '0, '0);
    chk("wr_back_pc", pc, saved);
    nop();
    chk("wr_new", if_id_instr, 32'hCAFE_F00D);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(3) == 0),
           ($urandom_range(6) == 0), 16'($urandom), ($urandom_range(9) == 0),
           26'($urandom), ($urandom_range(4) == 0), AW'($urandom), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction-fetch stage that feeds the decode stage (control unit, ALU control, register file).
- Holds the PC and a word-addressed instruction memory with a bench/loader write port.
- Captures each fetched instruction into an IF/ID register and exposes its decode fields.
- Handles stall, branch and jump redirects with squash of the wrong-path fetch.

Parameters:
IMEM_AW, 8, instruction memory word-address width (depth = 2**IMEM_AW words of 32 bits)
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous active-high reset
stall  input  1  hold PC and IF/ID (hazard from decode)
branch_taken  input  1  taken branch for instruction currently in IF/ID
branch_imm  input  16  raw immediate of that branch
jump  input  1  jump for instruction currently in IF/ID
jump_index  input  26  raw jump index of that jump
imem_we  input  1  instruction memory write enable
imem_waddr  input  IMEM_AW  word address for write
imem_wdata  input  32  write data
pc  output  32  current fetch PC
if_id_instr  output  32  latched instruction
if_id_pc4  output  32  PC+4 of latched instruction
if_id_valid  output  1  IF/ID holds a real instruction
op  output  6  if_id_instr[31:26]
func  output  6  if_id_instr[5:0]
rs  output  5  if_id_instr[25:21]
rt  output  5  if_id_instr[20:16]
rd  output  5  if_id_instr[15:11]
fetch_count  output  32  number of instructions delivered with valid=1

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-redirect):
  - pc=RESET_PC; if_id_instr=0; if_id_pc4=0; if_id_valid=0; fetch_count=0.
  - Memory contents are not reset.
- Memory:
  - Read is combinational at word index pc[IMEM_AW+1:2]; higher PC bits are ignored, so the address wraps modulo depth.
  - Write is synchronous on posedge when imem_we.
  - A write to the word being fetched in the same cycle: IF/ID captures the old data.
- Next PC, priority high to low:
  1. reset
  2. stall: pc, IF/ID and fetch_count all hold; branch_taken and jump are ignored and must be re-presented by decode.
  3. jump: pc <= {if_id_pc4[31:28], jump_index, 2'b00}.
  4. branch_taken: pc <= if_id_pc4 + (sign_extend(branch_imm) << 2), using 32-bit wrap-around arithmetic.
  5. Otherwise: pc <= pc + 4, which wraps 32'hFFFF_FFFC to 0.
- Redirects (jump or branch_taken) are honoured only when if_id_valid=1; otherwise they are ignored.
- IF/ID update when not stalled:
  - Normal cycle: if_id_instr <= mem[pc]; if_id_pc4 <= pc+4; if_id_valid <= 1.
  - Redirect cycle: if_id_valid <= 0 and if_id_instr <= 0 (squash). This is a fixed one-cycle bubble.
- Latency: an instruction at PC X appears on if_id_instr one posedge after pc==X, provided there is no stall or redirect.
- Decode fields (op, func, rs, rt, rd) are pure combinational slices of if_id_instr.
  - They show 0 (op=0, func=0) when squashed; decode must gate control on if_id_valid.
- fetch_count increments by 1 on each posedge where if_id_valid becomes or stays 1 with new data (non-stall, non-redirect cycle). It wraps at 2**32.
- pc[1:0] are always 0: the jump target is aligned by construction, and branch and +4 arithmetic preserve alignment since RESET_PC must be aligned.

Test Plan:
- Preload mem[0..3] = 32'h012A4020, 32'h8D090004, 32'hAD090008, 32'h00000000; release reset -> pc steps 0,4,8,C; if_id_instr shows each word one cycle later; op=0/35/43/0; func=32 for word 0; fetch_count=4 after 4 cycles.
- Assert reset while pc=8 and if_id_valid=1 -> pc=RESET_PC, if_id_valid=0, fetch_count=0 immediately, without waiting for a clock edge.
- Stall 3 cycles with pc=4 -> pc stays 4, if_id_instr and fetch_count unchanged; release -> fetch resumes at 4.
- IF/ID holds a beq with if_id_pc4=8, branch_taken=1, branch_imm=16'hFFFE -> next pc=0, if_id_valid=0 for one cycle, then mem[0] is delivered.
- IF/ID holds an instruction with if_id_pc4=32'h1000_0010, jump=1, jump_index=26'h0000040 -> pc=32'h1000_0100; the squashed slot shows instr=0, valid=0.
- jump and branch_taken asserted together while stall=1 -> no PC change; after stall drops with jump still high -> the jump target is taken, not the branch target. Separately: imem_we to the current fetch address in the same cycle -> old word is latched; the new word is seen on the next fetch of that address.
